// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch path.
//   fault_e : response fault code (ok / misaligned / out of range)
//   rsp_t   : one response entry {addr, instr, fault}
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
        fault_e             fault;
    } rsp_t;

endpackage

// File: rtl/imem_if.sv
// Fetch request/response bus between the fetch unit (master) and the
// instruction memory (slave).
//   req_valid/req_ready/req_addr : fetch request handshake and byte address
//   rsp_valid/rsp_ready          : response handshake
//   rsp_instr/rsp_addr/rsp_fault : returned word, echoed address, fault code
interface imem_if;
    import imem_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [INSTR_W-1:0] rsp_instr;
    logic [ADDR_W-1:0]  rsp_addr;
    fault_e             rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

endinterface

// File: rtl/imem_rsp_fifo.sv
// Synchronous FIFO of response entries; head is read combinationally.
//   clk   : clock
//   push  : write din at the tail (ignored when full)
//   pop   : drop the head entry (ignored when empty)
//   clear : synchronous clear of all entries, has priority over push/pop
//   full/empty : occupancy flags
//   head  : oldest entry, valid while !empty
module imem_rsp_fifo
    import imem_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic clk,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  rsp_t din,
    output logic full,
    output logic empty,
    output rsp_t head
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    rsp_t          store [RSP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // RSP_DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(RSP_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/imem_pipe.sv
// Clocked instruction memory for the fetch path with a fixed-latency read
// pipeline, in-order response buffer, fault reporting and flush.
//   clk, reset : clock and synchronous active-high reset
//   bus        : fetch request/response handshake (slave side)
//   flush      : drop everything in flight and buffered
//   prog_we/prog_addr/prog_data : program-load write port (word index)
module imem_pipe
    import imem_pkg::*;
#(
    parameter int               DEPTH     = 1024,
    parameter int               LATENCY   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0,
    parameter int               RSP_DEPTH = LATENCY + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    imem_if.slave                    bus,
    input  logic                     flush,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]       prog_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [CW-1:0]      outstanding;
    logic               accept;
    logic               pop;
    logic [ADDR_W:0]    diff;
    logic [AW-1:0]      idx;
    fault_e             fault;
    rsp_t               in_d;
    logic               push;
    rsp_t               push_d;
    logic               fifo_full;
    logic               fifo_empty;
    rsp_t               head;

    // Outstanding counts in-flight plus buffered entries, so the buffer can
    // never overflow and req_ready does not depend on rsp_ready.
    assign bus.req_ready = !reset && !flush && (outstanding < CW'(RSP_DEPTH)) && !fifo_full;
    assign accept        = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;

    // The extra top bit is the borrow: set when req_addr < BASE_ADDR.
    // DEPTH is a power of two, so any offset bit above the word index
    // means the address is past the end of memory.
    assign diff = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    assign idx  = diff[2 +: AW];

    always_comb begin
        fault = FAULT_NONE;
        if (diff[1:0] != 2'b00)
            fault = FAULT_MISALIGN;
        else if (diff[ADDR_W] || (|diff[ADDR_W-1:AW+2]))
            fault = FAULT_RANGE;
    end

    // Read is taken in the accept cycle, before the same-edge program write
    // lands, which gives read-first behaviour on a collision.
    assign in_d = '{addr:  bus.req_addr,
                    instr: (fault == FAULT_NONE) ? mem[idx] : '0,
                    fault: fault};

    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

    // LATENCY-1 register stages; the buffer push itself supplies the last
    // cycle of latency.
    if (LATENCY == 1) begin : g_direct
        assign push   = accept;
        assign push_d = in_d;
    end else begin : g_pipe
        logic [LATENCY-2:0] st_v;
        rsp_t               st_d [LATENCY-1];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                st_v <= '0;
            end else begin
                st_v[0] <= accept;
                for (int i = 1; i < LATENCY - 1; i++) st_v[i] <= st_v[i-1];
            end
        end

        always_ff @(posedge clk) begin
            st_d[0] <= in_d;
            for (int i = 1; i < LATENCY - 1; i++) st_d[i] <= st_d[i-1];
        end

        assign push   = st_v[LATENCY-2];
        assign push_d = st_d[LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (reset || flush)
            outstanding <= '0;
        else
            outstanding <= outstanding + CW'(accept) - CW'(pop);
    end

    imem_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .push  (push),
        .pop   (pop),
        .clear (flush | reset),
        .din   (push_d),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Outputs read as zero whenever no response is presented.
    assign bus.rsp_valid = !fifo_empty && !reset;
    assign bus.rsp_instr = bus.rsp_valid ? head.instr : '0;
    assign bus.rsp_addr  = bus.rsp_valid ? head.addr  : '0;
    assign bus.rsp_fault = bus.rsp_valid ? head.fault : FAULT_NONE;

endmodule

// File: tb/tb_imem_pipe.sv
module tb_imem_pipe;
    import imem_pkg::*;

    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam int          RD    = 3;
    localparam logic [63:0] BASE  = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;

    imem_if bus();

    imem_pipe #(
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .BASE_ADDR (BASE),
        .RSP_DEPTH (RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .flush     (flush),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
        int          t;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  fault;
        logic [31:0] instr;
    } fvec_t;

    exp_t        q[$];
    logic [31:0] mm [DEPTH];
    logic [63:0] base_m;
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic [31:0] got_i[$];
    logic [63:0] got_a[$];
    logic [1:0]  got_f[$];
    int          got_t[$];
    logic        obs_rdy;
    logic        obs_v;

    logic        d_v, d_rr, d_fl, d_we, d_rst;
    logic [63:0] d_a;
    logic [9:0]  d_wa;
    logic [31:0] d_wd;

    function automatic logic [31:0] pre(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic logic [1:0] ref_fault(input logic [63:0] a);
        if (a % 4 != 0) return 2'b01;
        if (a < base_m || (a - base_m) / 4 >= 64'(DEPTH)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic step();
        logic       exp_rdy, exp_v;
        logic [1:0] f;
        bus.req_valid = d_v;
        bus.req_addr  = d_a;
        bus.rsp_ready = d_rr;
        flush         = d_fl;
        reset         = d_rst;
        prog_we       = d_we;
        prog_addr     = d_wa;
        prog_data     = d_wd;
        #1;
        exp_rdy = !d_rst && !d_fl && (q.size() < RD);
        exp_v   = !d_rst && (q.size() > 0) && (q[0].t + LAT <= cyc_n);
        obs_rdy = bus.req_ready;
        obs_v   = bus.rsp_valid;
        check("req_ready", 64'(obs_rdy), 64'(exp_rdy));
        check("rsp_valid", 64'(obs_v), 64'(exp_v));
        if (exp_v) begin
            check("rsp_instr", 64'(bus.rsp_instr), 64'(q[0].instr));
            check("rsp_addr", bus.rsp_addr, q[0].addr);
            check("rsp_fault", 64'(bus.rsp_fault), 64'(q[0].fault));
        end
        if (d_rst) begin
            check("rst_instr", 64'(bus.rsp_instr), 64'h0);
            check("rst_addr", bus.rsp_addr, 64'h0);
            check("rst_fault", 64'(bus.rsp_fault), 64'h0);
        end
        if (obs_v && d_rr) begin
            got_i.push_back(bus.rsp_instr);
            got_a.push_back(bus.rsp_addr);
            got_f.push_back(bus.rsp_fault);
            got_t.push_back(cyc_n);
        end
        if (d_rst || d_fl) begin
            q.delete();
        end else begin
            if (exp_v && d_rr) void'(q.pop_front());
            if (d_v && exp_rdy) begin
                f = ref_fault(d_a);
                q.push_back('{addr: d_a,
                              instr: (f == 2'b00) ? mm[(d_a - base_m) / 4] : 32'h0,
                              fault: f, t: cyc_n});
            end
        end
        if (d_we) mm[d_wa] = d_wd;
        @(posedge clk);
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic defaults();
        d_v = 0; d_a = '0; d_rr = 1; d_fl = 0; d_we = 0; d_wa = '0; d_wd = '0; d_rst = 0;
    endtask

    task automatic idle(input int n);
        defaults();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        got_i.delete(); got_a.delete(); got_f.delete(); got_t.delete();
    endtask

    initial begin
        fvec_t fv[5];
        int    t0, acc_cnt;
        base_m = BASE;
        fv[0] = '{addr: 64'h6,    fault: 2'b01, instr: 32'h0};
        fv[1] = '{addr: 64'h1000, fault: 2'b10, instr: 32'h0};
        fv[2] = '{addr: 64'h1002, fault: 2'b01, instr: 32'h0};
        fv[3] = '{addr: 64'hFFC,  fault: 2'b00, instr: pre(1023)};
        fv[4] = '{addr: 64'h24,   fault: 2'b00, instr: pre(9)};

        // reset held 3 cycles with a request pending
        defaults();
        d_rst = 1; d_v = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_in_reset", 64'(obs_rdy), 64'h0);
            check("vld_in_reset", 64'(obs_v), 64'h0);
        end
        defaults();
        step();
        check("rdy_after_reset", 64'(obs_rdy), 64'h1);

        // preload whole memory
        for (int i = 0; i < DEPTH; i++) begin
            defaults();
            d_we = 1; d_wa = 10'(i); d_wd = pre(i);
            step();
        end

        // streaming
        for (int i = 0; i < 8; i++) begin
            defaults();
            d_we = 1; d_wa = 10'(i); d_wd = 32'h1000_0000 + 32'(i);
            step();
        end
        clear_log();
        t0 = cyc_n;
        for (int i = 0; i < 8; i++) begin
            defaults();
            d_v = 1; d_a = 64'(4 * i);
            step();
        end
        idle(5);
        check("stream_count", 64'(got_i.size()), 64'd8);
        for (int i = 0; i < got_i.size(); i++) begin
            check("stream_instr", 64'(got_i[i]), 64'(32'h1000_0000 + 32'(i)));
            check("stream_addr", got_a[i], 64'(4 * i));
            check("stream_fault", 64'(got_f[i]), 64'h0);
            check("stream_cycle", 64'(got_t[i]), 64'(t0 + LAT + i));
        end

        // backpressure
        clear_log();
        acc_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            defaults();
            d_v = 1; d_rr = 0; d_a = 64'h40 + 64'(4 * acc_cnt);
            step();
            if (obs_rdy) acc_cnt++;
            if (bus.rsp_valid) check("bp_head_stable", bus.rsp_addr, 64'h40);
        end
        check("bp_accepts", 64'(acc_cnt), 64'd3);
        defaults();
        d_v = 1; d_a = 64'h40 + 64'(4 * acc_cnt);
        step();
        check("bp_rdy_at_pop", 64'(obs_rdy), 64'h0);
        step();
        check("bp_rdy_after_pop", 64'(obs_rdy), 64'h1);
        idle(6);
        check("bp_count", 64'(got_a.size()), 64'd4);
        for (int i = 0; i < got_a.size(); i++)
            check("bp_order", got_a[i], 64'h40 + 64'(4 * i));

        // fault table
        for (int k = 0; k < 5; k++) begin
            clear_log();
            defaults();
            d_v = 1; d_a = fv[k].addr;
            step();
            idle(4);
            check("fault_count", 64'(got_f.size()), 64'd1);
            check("fault_code", 64'(got_f[0]), 64'(fv[k].fault));
            check("fault_instr", 64'(got_i[0]), 64'(fv[k].instr));
            check("fault_addr", got_a[0], fv[k].addr);
        end

        // flush with 3 outstanding
        clear_log();
        for (int i = 0; i < 3; i++) begin
            defaults();
            d_v = 1; d_rr = 0; d_a = 64'h100 + 64'(4 * i);
            step();
        end
        defaults();
        d_fl = 1; d_v = 1; d_rr = 0; d_a = 64'h10C;
        step();
        check("flush_rdy", 64'(obs_rdy), 64'h0);
        defaults();
        step();
        check("flush_vld_next", 64'(obs_v), 64'h0);
        defaults();
        d_v = 1; d_a = 64'h20;
        step();
        idle(5);
        check("flush_count", 64'(got_i.size()), 64'd1);
        check("flush_instr", 64'(got_i[0]), 64'(pre(8)));
        check("flush_addr", got_a[0], 64'h20);

        // write/read collision
        defaults();
        d_we = 1; d_wa = 10'd5; d_wd = 32'hAAAA_AAAA;
        step();
        clear_log();
        defaults();
        d_we = 1; d_wa = 10'd5; d_wd = 32'h5555_5555; d_v = 1; d_a = 64'h14;
        step();
        defaults();
        d_v = 1; d_a = 64'h14;
        step();
        idle(5);
        check("coll_count", 64'(got_i.size()), 64'd2);
        check("coll_old", 64'(got_i[0]), 64'hAAAA_AAAA);
        check("coll_new", 64'(got_i[1]), 64'h5555_5555);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            defaults();
            r     = int'($urandom % 10);
            d_v   = ($urandom % 4) != 0;
            case (r)
                6:       d_a = 64'h1000 + 64'({$urandom % 4096, 2'b00});
                7:       d_a = 64'({$urandom % 1024, 2'b00}) + 64'(1 + $urandom % 3);
                8:       d_a = {$urandom, $urandom};
                9:       d_a = 64'hFFC;
                default: d_a = 64'({$urandom % 1024, 2'b00});
            endcase
            d_rr  = ($urandom % 3) != 0;
            d_fl  = ($urandom % 40) == 0;
            d_we  = ($urandom % 5) == 0;
            d_wa  = 10'($urandom);
            d_wd  = $urandom;
            d_rst = ($urandom % 300) == 0;
            step();
        end
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
